// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares uart_wrap's transmit port between NREQ byte streams.
// Ownership lasts a whole packet; every write is paced against txempty and lock.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int ACCEPT_TO = 16,
    parameter int CW        = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    input  logic              uart_lock,
    input  logic              uart_txempty,
    output logic [7:0]        uart_txdata,
    output logic              uart_write,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic [1:0]        dbg_state
);
    localparam int IW = $clog2(NREQ);

    // Handshake: a byte moves when req_valid[i] is high and req_ready[i] pulses for one
    // cycle; the requester must present its next byte (or drop valid) the cycle after.
    typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, CAPT = 2'd2, WAIT_ACC = 2'd3} state_t;

    state_t          state, state_d;
    logic [IW-1:0]   ptr, ptr_d, owner, owner_d, pick;
    logic            last_q, last_d, found;
    logic [CW-1:0]   cnt, cnt_d;
    logic [NREQ-1:0] grant_d, ready_d;
    logic [7:0]      txdata_d;
    logic            write_d, err_d;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        return NREQ'(1) << i;
    endfunction

    assign dbg_state = state;

    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        owner_d  = owner;
        last_d   = last_q;
        cnt_d    = cnt;
        grant_d  = grant;
        ready_d  = '0;
        txdata_d = uart_txdata;
        write_d  = 1'b0;
        err_d    = err_clr ? 1'b0 : timeout_err;
        found    = 1'b0;
        pick     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[rr_idx(ptr, k)]) begin
                found = 1'b1;
                pick  = rr_idx(ptr, k);
            end
        end
        case (state)
            IDLE: begin
                if (uart_lock && found) begin
                    grant_d = onehot(pick);
                    owner_d = pick;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (req_valid[owner] && uart_txempty && uart_lock) begin
                    ready_d  = onehot(owner);
                    txdata_d = req_data[8*owner +: 8];
                    last_d   = req_last[owner];
                    state_d  = CAPT;
                end
            end
            CAPT: begin
                // The byte is already consumed; only the strobe waits for lock.
                if (uart_lock) begin
                    write_d = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_ACC;
                end
            end
            WAIT_ACC: begin
                // The strobe cycle itself is skipped: the wrapper cannot react yet.
                if (!uart_write) begin
                    if (!uart_txempty || cnt == CW'(ACCEPT_TO)) begin
                        if (uart_txempty) err_d = 1'b1;
                        if (last_q) begin
                            grant_d = '0;
                            ptr_d   = (owner == IW'(NREQ-1)) ? '0 : owner + IW'(1);
                            state_d = IDLE;
                        end else begin
                            state_d = OWN;
                        end
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            last_q      <= 1'b0;
            cnt         <= '0;
            grant       <= '0;
            req_ready   <= '0;
            uart_txdata <= 8'h00;
            uart_write  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            owner       <= owner_d;
            last_q      <= last_d;
            cnt         <= cnt_d;
            grant       <= grant_d;
            req_ready   <= ready_d;
            uart_txdata <= txdata_d;
            uart_write  <= write_d;
            timeout_err <= err_d;
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single transmit side of uart_wrap between NREQ on-chip requesters.
- Each requester offers bytes on a valid/ready handshake. The block grants the UART round-robin and holds the grant for a whole packet, up to and including the byte flagged last.
- It sequences the wrapper's write pulse against txempty and lock, and flags a sticky error if the wrapper never accepts a byte.
- Sits between client logic (e.g. echo/command responders) and uart_wrap's txdata/write/txempty/lock pins.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- ACCEPT_TO, 16: cycles to wait for txempty to fall after a write pulse before declaring timeout.
- CW, 5: width of the accept-timeout counter; 2^CW > ACCEPT_TO.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NREQ  byte is last of its packet.
- req_ready  out  NREQ  one-cycle pulse; the byte is consumed.
- grant  out  NREQ  one-hot current owner; 0 when idle.
- uart_lock  in  1  uart_wrap baud lock.
- uart_txempty  in  1  uart_wrap transmit holding register empty.
- uart_txdata  out  8  byte to uart_wrap.
- uart_write  out  1  one-cycle write strobe to uart_wrap.
- timeout_err  out  1  sticky accept-timeout flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (rst=0, asynchronous):
  - req_ready=0, grant=0, uart_txdata=8'h00, uart_write=0, timeout_err=0.
  - RR pointer=0, state=IDLE.
  - Reset asserted mid-packet aborts the packet; nothing is replayed.
- All outputs are registered.
- IDLE:
  - If uart_lock=1 and any req_valid=1, choose the first valid index at or above the pointer, wrapping modulo NREQ.
  - Set grant one-hot next cycle; go to OWN.
  - With uart_lock=0, no grant is issued.
- OWN:
  - When req_valid[owner]=1, uart_txempty=1 and uart_lock=1 in cycle t:
    - cycle t+1: req_ready[owner]=1 and the byte is captured to uart_txdata; the last flag is latched.
    - cycle t+2: uart_write=1 for exactly one cycle; go to WAIT_ACC.
  - Otherwise stall with grant held. A requester dropping valid mid-packet keeps the grant; there is no idle timeout.
- WAIT_ACC:
  - Counter starts at 0 the cycle after uart_write.
  - Done when uart_txempty=0 is observed, or the counter reaches ACCEPT_TO.
  - On timeout: set timeout_err, then proceed as if the byte was accepted.
  - On done, if latched last=1: grant=0, pointer=owner+1 (wraps to 0), go to IDLE. Otherwise return to OWN.
  - A new write is never issued until uart_txempty=1 is seen again in OWN.
- uart_lock falling in any state: no new uart_write is issued. Grant and packet ownership are retained; transmission resumes when lock returns.
- uart_txdata holds its last value between writes.
- req_ready is never asserted to a non-owner and never on two consecutive cycles.
- err_clr=1 clears timeout_err. A timeout occurring in the same cycle wins: the flag stays set.
- If no other requester is valid, the same requester may win again immediately after its own packet.

Test Plan:
- Single requester 0 sends 8'h55 with last=1, lock=1. txempty model drops 2 cycles after write and rises 10 cycles later. Required: one req_ready pulse, uart_write 1 cycle later with uart_txdata=8'h55, grant returns to 0, pointer=1.
- Requesters 1 and 2 both hold 3-byte packets (8'hA0..A2, 8'hB0..B2). Required: the UART sees A0,A1,A2,B0,B1,B2 with no interleave; grant switches 1→2 only after A2 is accepted.
- All four requesters continuously valid with 1-byte packets. Required: grant order 0,1,2,3,0, and every requester is served once per 4 packets.
- Lock held at 0 for 200 cycles with requester 3 valid. Required: no grant and no write. Raise lock: grant[3] asserts next cycle and the byte is transmitted.
- txempty stuck at 1 after a write. Required: timeout_err set ACCEPT_TO cycles after the write and the next byte proceeds. Pulse err_clr together with a fresh timeout: flag stays 1. A later err_clr alone clears it.
- Assert rst mid-packet, in WAIT_ACC. Required: all outputs zero immediately. After release, arbitration restarts from requester 0.
